debounce_scan_ctrl: RTL and testbench

Multi-channel debounce controller. Up to N_CH noisy inputs, such as pushbuttons and switches, share one sample-tick prescaler. Each channel has a small stability counter and a 4-state FSM. Debounced level changes are queued as per-channel events and handed to the downstream consumer one at a time through a round-robin valid/ready port. The block sits between the pad synchronisers and the front-panel control logic, and replaces per-input free-running debouncers.

---
 rtl/debounce_scan_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_debounce_scan_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_scan_ctrl.sv
// debounce_scan_ctrl: tick-sampled multi-channel debouncer with a
// per-channel pending store and round-robin valid/ready event port.
module debounce_scan_ctrl #(
  parameter int N_CH       = 4,
  parameter int TICK_DIV   = 10,
  parameter int STABLE_CNT = 10,
  parameter int CH_W       = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] ch_mask,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] db_out,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_level,
  output logic            evt_ovf
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_CNT + 1);

  localparam logic [1:0] STABLE_LO = 2'd0;
  localparam logic [1:0] CHK_HI    = 2'd1;
  localparam logic [1:0] STABLE_HI = 2'd2;
  localparam logic [1:0] CHK_LO    = 2'd3;

  logic [PW-1:0]   presc_q, presc_d;
  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q, sync2_d;
  logic [1:0]      st_q [N_CH];
  logic [1:0]      st_d [N_CH];
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0] db_q, db_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] plvl_q, plvl_d;
  logic            vld_q, vld_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            lvl_q, lvl_d;
  logic            ovf_q, ovf_d;
  logic [CH_W-1:0] last_q, last_d;

  logic            tick;
  logic [N_CH-1:0] acc;
  logic [N_CH-1:0] clr;
  logic            hit;
  logic [CH_W-1:0] grant;

  always_comb begin
    tick    = en && (presc_q == PW'(TICK_DIV - 1));
    presc_d = (!en || tick) ? '0 : presc_q + PW'(1);
    sync1_d = noisy_in;
    sync2_d = sync1_q;
  end

  always_comb begin
    db_d = db_q;
    acc  = '0;
    for (int c = 0; c < N_CH; c++) begin
      st_d[c]  = st_q[c];
      cnt_d[c] = cnt_q[c];
      if (!ch_mask[c]) begin
        st_d[c]  = db_q[c] ? STABLE_HI : STABLE_LO;
        cnt_d[c] = '0;
      end else if (tick) begin
        unique case (st_q[c])
          STABLE_LO: if (sync2_q[c]) begin
            st_d[c]  = CHK_HI;
            cnt_d[c] = CW'(1);
          end
          CHK_HI: if (!sync2_q[c]) begin
            st_d[c]  = STABLE_LO;
            cnt_d[c] = '0;
          end else if (cnt_q[c] == CW'(STABLE_CNT - 1)) begin
            st_d[c]  = STABLE_HI;
            cnt_d[c] = '0;
            db_d[c]  = 1'b1;
            acc[c]   = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] + CW'(1);
          end
          STABLE_HI: if (!sync2_q[c]) begin
            st_d[c]  = CHK_LO;
            cnt_d[c] = CW'(1);
          end
          CHK_LO: if (sync2_q[c]) begin
            st_d[c]  = STABLE_HI;
            cnt_d[c] = '0;
          end else if (cnt_q[c] == CW'(STABLE_CNT - 1)) begin
            st_d[c]  = STABLE_LO;
            cnt_d[c] = '0;
            db_d[c]  = 1'b0;
            acc[c]   = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] + CW'(1);
          end
          default: begin
            st_d[c]  = STABLE_LO;
            cnt_d[c] = '0;
          end
        endcase
      end
    end
  end

  // Round-robin search starting one past the last grant.
  always_comb begin : arb
    int idx;
    logic [CH_W-1:0] cand;
    hit   = 1'b0;
    grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx  = (int'(last_q) + 1 + i) % N_CH;
      cand = CH_W'(idx);
      if (!hit && pend_q[cand]) begin
        hit   = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    vld_d  = vld_q;
    ch_d   = ch_q;
    lvl_d  = lvl_q;
    last_d = last_q;
    clr    = '0;
    if (!vld_q || evt_ready) begin
      vld_d = hit;
      if (hit) begin
        ch_d       = grant;
        lvl_d      = plvl_q[grant];
        last_d     = grant;
        clr[grant] = 1'b1;
      end
    end
    pend_d = (pend_q & ~clr) | acc;
    plvl_d = (acc & db_d) | (~acc & plvl_q);
    ovf_d  = |(pend_q & ~clr & acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      pend_q  <= '0;
      plvl_q  <= '0;
      vld_q   <= 1'b0;
      ch_q    <= '0;
      lvl_q   <= 1'b0;
      ovf_q   <= 1'b0;
      last_q  <= CH_W'(N_CH - 1);
      for (int c = 0; c < N_CH; c++) begin
        st_q[c]  <= STABLE_LO;
        cnt_q[c] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      pend_q  <= pend_d;
      plvl_q  <= plvl_d;
      vld_q   <= vld_d;
      ch_q    <= ch_d;
      lvl_q   <= lvl_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
      for (int c = 0; c < N_CH; c++) begin
        st_q[c]  <= st_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign db_out    = db_q;
  assign evt_valid = vld_q;
  assign evt_ch    = ch_q;
  assign evt_level = lvl_q;
  assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// tb_debounce_scan_ctrl: directed scenarios checked against an
// event-level model of the debouncer and event port.
module tb_debounce_scan_ctrl;
  localparam int N_CH = 4;
  localparam int TICK_DIV = 10;
  localparam int STABLE_CNT = 10;
  localparam int CH_W = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b1;
  logic [N_CH-1:0] ch_mask = 4'hF;
  logic [N_CH-1:0] noisy_in = 4'h0;
  logic [N_CH-1:0] db_out;
  logic            evt_valid;
  logic            evt_ready = 1'b1;
  logic [CH_W-1:0] evt_ch;
  logic            evt_level;
  logic            evt_ovf;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  debounce_scan_ctrl #(
    .N_CH(N_CH), .TICK_DIV(TICK_DIV),
    .STABLE_CNT(STABLE_CNT), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .ch_mask(ch_mask), .noisy_in(noisy_in),
    .db_out(db_out), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_ch(evt_ch),
    .evt_level(evt_level), .evt_ovf(evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: a level flips after STABLE_CNT consecutive ticks on which
  // the synchronised input disagrees with it; events queue per channel.
  int       m_presc = 0;
  bit [3:0] m_s1 = 0, m_s2 = 0, m_db = 0;
  bit [3:0] m_pend = 0, m_plvl = 0;
  int       m_run [N_CH];
  bit       m_valid = 0, m_lvl = 0, m_ovf = 0;
  int       m_ch = 0, m_last = N_CH - 1;

  always @(posedge clk) begin : model
    bit tick;
    bit got;
    bit [3:0] acc;
    bit [3:0] ndb;
    int pick;
    if (rst) begin
      m_presc = 0; m_s1 = 0; m_s2 = 0; m_db = 0;
      m_pend = 0; m_plvl = 0; m_valid = 0;
      m_lvl = 0; m_ovf = 0; m_ch = 0;
      m_last = N_CH - 1;
      for (int c = 0; c < N_CH; c++) m_run[c] = 0;
    end else begin
      tick = en && (m_presc == TICK_DIV - 1);
      m_presc = (!en || tick) ? 0 : m_presc + 1;
      acc = 0;
      ndb = m_db;
      for (int c = 0; c < N_CH; c++) begin
        if (!ch_mask[c]) m_run[c] = 0;
        else if (tick) begin
          if (m_s2[c] != m_db[c]) begin
            m_run[c]++;
            if (m_run[c] == STABLE_CNT) begin
              ndb[c] = ~m_db[c];
              m_run[c] = 0;
              acc[c] = 1;
            end
          end else m_run[c] = 0;
        end
      end
      m_ovf = 0;
      if (!m_valid || evt_ready) begin
        got = 0;
        pick = 0;
        for (int i = 1; i <= N_CH; i++)
          if (!got && m_pend[(m_last + i) % N_CH]) begin
            got = 1;
            pick = (m_last + i) % N_CH;
          end
        m_valid = got;
        if (got) begin
          m_ch = pick;
          m_lvl = m_plvl[pick];
          m_pend[pick] = 0;
          m_last = pick;
        end
      end
      for (int c = 0; c < N_CH; c++)
        if (acc[c]) begin
          if (m_pend[c]) m_ovf = 1;
          m_pend[c] = 1;
          m_plvl[c] = ndb[c];
        end
      m_db = ndb;
      m_s2 = m_s1;
      m_s1 = noisy_in;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_db_out", db_out, m_db);
      chk("m_evt_valid", evt_valid, m_valid);
      chk("m_evt_ovf", evt_ovf, m_ovf);
      if (m_valid) begin
        chk("m_evt_ch", evt_ch, m_ch);
        chk("m_evt_level", evt_level, m_lvl);
      end
    end
  end

  task automatic rst_pulse();
    rst = 1'b1;
    noisy_in = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int ovfs;
    bit seen;
    bit pstall;
    int pch;
    int hs_ch[$];
    int hs_lv[$];
    int hs_t[$];

    repeat (2) @(negedge clk);
    started = 1'b1;
    chk("rst_db_out", db_out, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_ch", evt_ch, 0);
    chk("rst_evt_level", evt_level, 0);
    chk("rst_evt_ovf", evt_ovf, 0);

    // Single rising edge on ch0.
    rst = 1'b0;
    noisy_in = 4'b0001;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!db_out[0] && n < 150);
    chk("t1_lat_range", (n >= 93 && n <= 102), 1);
    chk("t1_lat_exact", n, 100);
    @(negedge clk);
    chk("t1_valid", evt_valid, 1);
    chk("t1_ch", evt_ch, 0);
    chk("t1_level", evt_level, 1);

    // Glitch burst on ch1 must be rejected.
    @(negedge clk);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      noisy_in[1] = (i % 2 == 0);
      seen |= evt_valid;
      @(negedge clk);
    end
    noisy_in[1] = 1'b0;
    repeat (250) begin
      seen |= evt_valid;
      @(negedge clk);
    end
    chk("t2_db1", db_out[1], 0);
    chk("t2_no_evt", seen, 0);

    // All channels rise together, ready held high.
    rst_pulse();
    noisy_in = 4'hF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (db_out != 4'hF && n < 150);
    chk("t3_db_all", db_out, 4'hF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (evt_valid) begin
        hs_ch.push_back(int'(evt_ch));
        hs_lv.push_back(int'(evt_level));
        hs_t.push_back(i);
      end
    end
    chk("t3_rise_cnt", hs_ch.size(), 4);
    for (int j = 0; j < hs_ch.size(); j++) begin
      chk("t3_rise_ch", hs_ch[j], j);
      chk("t3_rise_lv", hs_lv[j], 1);
      chk("t3_rise_t", hs_t[j], j);
    end

    // Falling edge with a toggling consumer.
    hs_ch.delete();
    hs_lv.delete();
    evt_ready = 1'b0;
    noisy_in = 4'h0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (db_out != 4'h0 && n < 150);
    chk("t3_db_none", db_out, 0);
    pstall = 0;
    pch = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pstall) chk("t3_hold_ch", evt_ch, pch);
      evt_ready = (i % 2 == 1);
      pstall = evt_valid && !evt_ready;
      pch = int'(evt_ch);
      if (evt_valid && evt_ready) begin
        hs_ch.push_back(int'(evt_ch));
        hs_lv.push_back(int'(evt_level));
      end
    end
    chk("t3_fall_cnt", hs_ch.size(), 4);
    for (int j = 0; j < hs_ch.size(); j++) begin
      chk("t3_fall_ch", hs_ch[j], j);
      chk("t3_fall_lv", hs_lv[j], 0);
    end

    // Overwrite of a pending event on ch2.
    evt_ready = 1'b0;
    rst_pulse();
    ovfs = 0;
    noisy_in[2] = 1'b1;
    repeat (120) begin
      @(negedge clk);
      ovfs += int'(evt_ovf);
    end
    noisy_in[2] = 1'b0;
    repeat (120) begin
      @(negedge clk);
      ovfs += int'(evt_ovf);
    end
    noisy_in[2] = 1'b1;
    repeat (120) begin
      @(negedge clk);
      ovfs += int'(evt_ovf);
    end
    chk("t4_ovf_pulses", ovfs, 1);
    hs_ch.delete();
    hs_lv.delete();
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (evt_valid) begin
        hs_ch.push_back(int'(evt_ch));
        hs_lv.push_back(int'(evt_level));
      end
      @(negedge clk);
    end
    chk("t4_evt_cnt", hs_ch.size(), 2);
    for (int j = 0; j < hs_ch.size(); j++) begin
      chk("t4_ch", hs_ch[j], 2);
      chk("t4_lv", hs_lv[j], 1);
    end

    // Masking ch3 mid-check.
    rst_pulse();
    noisy_in = 4'b1000;
    repeat (30) @(negedge clk);
    ch_mask = 4'b0111;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      seen |= evt_valid;
    end
    chk("t5_db3_masked", db_out[3], 0);
    chk("t5_no_evt", seen, 0);
    ch_mask = 4'hF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!db_out[3] && n < 150);
    chk("t5_lat_exact", n, 100);
    @(negedge clk);
    chk("t5_valid", evt_valid, 1);
    chk("t5_ch", evt_ch, 3);
    chk("t5_level", evt_level, 1);

    // Reset while an event is presented and others are pending.
    evt_ready = 1'b0;
    noisy_in = 4'b1011;
    repeat (110) @(negedge clk);
    chk("t6_valid_pre", evt_valid, 1);
    chk("t6_db_pre", db_out, 4'b1011);
    rst_pulse();
    chk("t6_db", db_out, 0);
    chk("t6_valid", evt_valid, 0);
    chk("t6_ch", evt_ch, 0);
    chk("t6_level", evt_level, 0);
    chk("t6_ovf", evt_ovf, 0);
    evt_ready = 1'b1;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      seen |= evt_valid;
    end
    chk("t6_no_stale", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
